// File: rtl/nv_clk_gate_pkg.sv
// Shared types and constants for the partition clock-gate controller.
// State encodings match the gate_state output: ON=0, DRAIN=1, OFF=2, WAKE=3.
package nv_clk_gate_pkg;

    typedef enum logic [1:0] {
        GS_ON    = 2'd0,
        GS_DRAIN = 2'd1,
        GS_OFF   = 2'd2,
        GS_WAKE  = 2'd3
    } gate_state_e;

    localparam int unsigned STAT_W = 32;

    // Requesters may only be granted in states where the gated clock is
    // guaranteed to be running and will keep running.
    function automatic logic is_grantable(input gate_state_e s);
        return (s == GS_ON) || (s == GS_DRAIN);
    endfunction

endpackage

// File: rtl/nv_clk_gate_stat_cnt.sv
// Saturating, clearable event counter used for gated-cycle statistics.
// Clear has priority over increment; the count sticks at all-ones.
module nv_clk_gate_stat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;

    // Counter register: clear beats increment, increment stops at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {W{1'b0}};
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/nv_clk_gate_ctrl.sv
// Idle-detect controller producing clk_en for one partition's clock-gate cell.
// Merges busy/wake from NUM_REQ requesters, closes the clock after a
// programmable idle hysteresis and reopens it with a fixed settle latency
// before granting. Optional gated-cycle statistics are built when the macro
// NV_CLK_GATE_CTRL_STAT_EN is defined; otherwise stat_gated_cycles is 0.
module nv_clk_gate_ctrl
    import nv_clk_gate_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   cfg_idle_thresh,
    input  logic               cfg_force_on,
    input  logic [NUM_REQ-1:0] req_busy,
    input  logic [NUM_REQ-1:0] req_wake,
    output logic [NUM_REQ-1:0] req_grant,
    output logic               clk_en,
    output logic [1:0]         gate_state,
    input  logic               stat_clr,
    output logic [STAT_W-1:0]  stat_gated_cycles
);

    // Wake counter must hold the value WAKE_LAT (>=1).
    localparam int WK_W = (WAKE_LAT < 2) ? 1 : $clog2(WAKE_LAT + 1);

    gate_state_e        state_q, state_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [WK_W-1:0]    wake_cnt_q, wake_cnt_d;
    logic               clk_en_q;
    logic [NUM_REQ-1:0] req_grant_q;
    logic               act_s;

    // A busy requester in OFF is a protocol violation but is still treated
    // as activity so the clock gets reopened rather than the request lost.
    assign act_s = (|req_busy) | (|req_wake) | cfg_force_on;

    // Next-state logic for the gate FSM and its idle/wake counters.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            GS_ON: begin
                if (act_s) begin
                    idle_cnt_d = {CNT_W{1'b0}};
                end else if (cfg_idle_thresh == {CNT_W{1'b0}}) begin
                    state_d    = GS_OFF;
                    idle_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d    = GS_DRAIN;
                    idle_cnt_d = CNT_W'(1);
                end
            end
            GS_DRAIN: begin
                // Activity wins over reaching threshold in the same cycle.
                if (act_s) begin
                    state_d    = GS_ON;
                    idle_cnt_d = {CNT_W{1'b0}};
                end else if (idle_cnt_q >= cfg_idle_thresh) begin
                    // >= so a threshold lowered mid-drain still closes.
                    state_d    = GS_OFF;
                    idle_cnt_d = {CNT_W{1'b0}};
                end else if (idle_cnt_q != {CNT_W{1'b1}}) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
            end
            GS_OFF: begin
                if (act_s) begin
                    state_d    = GS_WAKE;
                    wake_cnt_d = WK_W'(1);
                end else begin
                    wake_cnt_d = {WK_W{1'b0}};
                end
            end
            GS_WAKE: begin
                // WAKE never aborts; settle latency always completes.
                if (wake_cnt_q == WK_W'(WAKE_LAT)) begin
                    state_d    = GS_ON;
                    wake_cnt_d = {WK_W{1'b0}};
                end else begin
                    wake_cnt_d = wake_cnt_q + WK_W'(1);
                end
            end
            default: begin
                state_d    = GS_ON;
                idle_cnt_d = {CNT_W{1'b0}};
                wake_cnt_d = {WK_W{1'b0}};
            end
        endcase
    end

    // State, counters and outputs; clk_en and grants derive from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GS_ON;
            idle_cnt_q  <= {CNT_W{1'b0}};
            wake_cnt_q  <= {WK_W{1'b0}};
            clk_en_q    <= 1'b1;
            req_grant_q <= {NUM_REQ{1'b0}};
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            clk_en_q    <= (state_d != GS_OFF);
            req_grant_q <= {NUM_REQ{is_grantable(state_d)}} & req_wake;
        end
    end

    assign clk_en     = clk_en_q;
    assign req_grant  = req_grant_q;
    assign gate_state = state_q;

`ifdef NV_CLK_GATE_CTRL_STAT_EN
    logic gated_s;
    assign gated_s = ~clk_en_q;

    nv_clk_gate_stat_cnt #(
        .W (STAT_W)
    ) u_stat_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (stat_clr),
        .inc_i   (gated_s),
        .count_o (stat_gated_cycles)
    );
`else
    logic unused_stat_clr_s;
    assign unused_stat_clr_s  = stat_clr;
    assign stat_gated_cycles  = {STAT_W{1'b0}};
`endif

endmodule

// File: doc/nv_clk_gate_ctrl.md
Name: nv_clk_gate_ctrl

Overview:
- Idle-detect controller that generates the `clk_en` input of a power clock-gate cell for one partition.
- Merges busy/wake indications from NUM_REQ requesters.
- Gates the clock after a programmable idle hysteresis.
- Reopens the clock with a fixed settle latency before granting requesters.
- Sits in the always-on clock domain beside the gate cell it drives.

Parameters:
- NUM_REQ, 4, number of requesters.
- CNT_W, 8, width of idle threshold and idle counter.
- WAKE_LAT, 2, cycles clk_en is held high in WAKE before entering ON (>=1).

Ports:
- clk  input  1  ungated always-on clock.
- reset  input  1  synchronous, active-high reset.
- cfg_idle_thresh  input  CNT_W  idle hysteresis; sampled live every cycle.
- cfg_force_on  input  1  keeps the clock on; counts as activity.
- req_busy  input  NUM_REQ  requester has work in flight; legal only while granted.
- req_wake  input  NUM_REQ  requester needs the clock; held until req_grant, then until done.
- req_grant  output  NUM_REQ  registered; clock guaranteed running for that requester.
- clk_en  output  1  registered enable to the gate cell.
- gate_state  output  2  current state: ON=0, DRAIN=1, OFF=2, WAKE=3.
- stat_clr  input  1  clears the gated-cycle counter (optional feature).
- stat_gated_cycles  output  32  gated-cycle count (optional feature).

Behaviour:
- Reset values: state=ON, clk_en=1, req_grant=0, idle_cnt=0, wake_cnt=0, stat_gated_cycles=0.
  - Reset asserted mid-operation returns to these values on the next edge; an in-progress WAKE or DRAIN is discarded.
- Activity: act = |req_busy | |req_wake | cfg_force_on.
- ON (clk_en=1):
  - act=1: stay in ON.
  - act=0 and cfg_idle_thresh==0: go to OFF.
  - act=0 and cfg_idle_thresh!=0: go to DRAIN with idle_cnt=1.
- DRAIN (clk_en=1):
  - act=1: go to ON and clear idle_cnt.
  - act=0 and idle_cnt>=cfg_idle_thresh: go to OFF.
  - otherwise: idle_cnt+1.
  - The >= compare covers a threshold lowered mid-DRAIN.
- Net timing: with act low in cycles t..t+thresh, clk_en=0 from cycle t+thresh+1. Any act pulse restarts the count.
- OFF (clk_en=0):
  - act=1: go to WAKE with wake_cnt=1.
  - req_busy in OFF is a protocol violation; it is treated as a wake, not ignored.
- WAKE (clk_en=1):
  - wake_cnt==WAKE_LAT: go to ON.
  - otherwise: wake_cnt+1.
  - WAKE never aborts; if act drops during WAKE, the FSM still reaches ON and then runs the normal idle path.
- clk_en is registered from the next-state value: 0 exactly when next state is OFF.
- req_grant[i] <= (next_state==ON or DRAIN) & req_wake[i].
  - Grant drops the cycle after req_wake[i] drops.
  - Grant is never asserted while state is OFF or WAKE.
  - A wake arriving in ON or DRAIN is granted next cycle with no WAKE phase.
- Simultaneous events:
  - Requesters are independent; no arbitration.
  - A wake in the same cycle as DRAIN reaching threshold wins: transition is DRAIN->ON, not OFF.
- No output is combinational from inputs.

Optional Feature:
- Macro: NV_CLK_GATE_CTRL_STAT_EN.
- Defined: 32-bit counter increments each cycle clk_en==0.
  - Saturates at 0xFFFFFFFF.
  - stat_clr=1 zeroes it; clear wins over increment.
  - Output is registered.
- Undefined: counter logic is absent, stat_gated_cycles is tied to 0, and stat_clr is ignored.

Decomposition:
- Package nv_clk_gate_pkg:
  - state enum and encodings (ON/DRAIN/OFF/WAKE);
  - STAT_W=32 constant.
- Sub-module nv_clk_gate_stat_cnt: saturating clearable counter, instantiated only under the macro.
- FSM, idle counter and wake counter stay in the top module.

Test Plan:
- Reset then all inputs 0, thresh=3 -> state ON->DRAIN; clk_en=0 at cycle 4 after reset release; gate_state=2.
- In OFF, pulse req_wake[1]=1 held -> clk_en=1 next cycle, gate_state=3 for 2 cycles, req_grant[1]=1 one cycle after ON; drop wake -> grant 0 next cycle.
- thresh=5, idle 4 cycles, req_busy[0] one-cycle pulse, idle again -> clk_en stays 1 until 6 idle cycles after the pulse.
- thresh=0 -> clk_en=0 one cycle after act drops; cfg_force_on=1 in OFF -> WAKE then ON, stays ON.
- Reset asserted during WAKE (wake_cnt=1) -> next cycle state=ON, clk_en=1, req_grant=0.
- With macro: 10 gated cycles -> stat_gated_cycles=10; stat_clr -> 0; preload near 0xFFFFFFFF -> saturates. Without macro -> stat_gated_cycles=0 throughout.
